// File: rtl/int_controller.sv
// Interrupt controller: per-source edge-latched pending bits, mask, fixed priority
// dispatch (source 0 highest) with a one-cycle request and no nesting until ret.
module int_src_pend (
  input  logic clock,
  input  logic reset,
  input  logic irq,
  input  logic clr,
  output logic pend
);
  logic irq_d;

  // A rising edge beats a clear landing on the same cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      irq_d <= 1'b0;
      pend  <= 1'b0;
    end else begin
      irq_d <= irq;
      pend  <= (irq & ~irq_d) | (pend & ~clr);
    end
  end
endmodule

module int_controller #(
  parameter int         N_SRC     = 4,
  parameter logic [7:0] BASE_ADDR = 8'hF0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N_SRC-1:0] irq,
  input  logic             ret,
  input  logic [7:0]       mem_addr,
  input  logic             mem_w_en,
  input  logic [7:0]       mem_w_data,
  output logic [7:0]       mem_r_data,
  output logic             int_req,
  output logic [7:0]       int_en,
  output logic [7:0]       int_vec,
  output logic [N_SRC-1:0] in_service
);
  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  state_t           state_q, state_d;
  logic [7:0]       en_q, vbase_q;
  logic [N_SRC-1:0] mask_q, pend, elig, win_oh, pend_clr, wr_clr;
  logic [2:0]       win_idx;
  logic             in_win, wr_en, dispatch;

  assign in_win = (mem_addr[7:2] == BASE_ADDR[7:2]);
  assign wr_en  = mem_w_en & in_win;
  assign elig   = pend & mask_q;

  // Descending scan so the lowest eligible index is the last one written.
  always_comb begin
    win_idx = 3'd0;
    win_oh  = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (elig[i]) begin
        win_idx = 3'(i);
        win_oh  = '0;
        win_oh[i] = 1'b1;
      end
    end
  end

  always_comb begin
    wr_clr = '0;
    if (wr_en && mem_addr[1:0] == 2'd2) wr_clr = mem_w_data[N_SRC-1:0];
    pend_clr = wr_clr | (dispatch ? win_oh : '0);
  end

  genvar g;
  generate
    for (g = 0; g < N_SRC; g++) begin : g_src
      int_src_pend u_pend (
        .clock (clock),
        .reset (reset),
        .irq   (irq[g]),
        .clr   (pend_clr[g]),
        .pend  (pend[g])
      );
    end
  endgenerate

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      en_q    <= 8'h00;
      mask_q  <= '0;
      vbase_q <= 8'h00;
    end else if (wr_en) begin
      case (mem_addr[1:0])
        2'd0:    en_q    <= mem_w_data;
        2'd1:    mask_q  <= mem_w_data[N_SRC-1:0];
        2'd3:    vbase_q <= mem_w_data;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    dispatch = 1'b0;
    case (state_q)
      IDLE: if (en_q[0] && elig != '0) begin
        dispatch = 1'b1;
        state_d  = REQ;
      end
      REQ:     state_d = SERVICE;
      SERVICE: if (ret) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      int_vec    <= 8'h00;
      in_service <= '0;
    end else if (dispatch) begin
      int_vec    <= vbase_q + {3'b000, win_idx, 2'b00};
      in_service <= win_oh;
    end else if (state_q == SERVICE && ret) begin
      in_service <= '0;
    end
  end

  assign int_req = (state_q == REQ);
  assign int_en  = en_q;

  always_comb begin
    mem_r_data = 8'h00;
    if (in_win) begin
      case (mem_addr[1:0])
        2'd0: mem_r_data = en_q;
        2'd1: mem_r_data[N_SRC-1:0] = mask_q;
        2'd2: mem_r_data[N_SRC-1:0] = pend;
        2'd3: mem_r_data = vbase_q;
      endcase
    end
  end
endmodule

// File: tb/tb_int_controller.sv
// Bench for int_controller: directed scenarios plus a randomized run against a
// transaction-level reference model of the controller.
module tb_int_controller;
  logic       clock = 0, reset = 0;
  logic [3:0] irq = '0;
  logic       ret = 0;
  logic [7:0] mem_addr = 8'h00, mem_w_data = 8'h00;
  logic       mem_w_en = 0;
  logic [7:0] mem_r_data, int_en, int_vec;
  logic       int_req;
  logic [3:0] in_service;

  int errors = 0, checks = 0;

  int_controller #(.N_SRC(4), .BASE_ADDR(8'hF0)) dut (
    .clock(clock), .reset(reset), .irq(irq), .ret(ret),
    .mem_addr(mem_addr), .mem_w_en(mem_w_en), .mem_w_data(mem_w_data),
    .mem_r_data(mem_r_data), .int_req(int_req), .int_en(int_en),
    .int_vec(int_vec), .in_service(in_service)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    mem_addr = a; mem_w_data = d; mem_w_en = 1; tick(); mem_w_en = 0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [7:0] d);
    mem_addr = a; #1; d = mem_r_data;
  endtask

  task automatic do_reset();
    irq = '0; ret = 0; mem_w_en = 0;
    @(posedge clock); #1; reset = 1; #2; reset = 0; tick();
  endtask

  task automatic pulse_ret();
    ret = 1; tick(); ret = 0;
  endtask

  task automatic test_reset();
    logic [7:0] d;
    do_reset();
    for (int a = 0; a < 4; a++) begin
      rd(8'hF0 + 8'(a), d);
      checks++; if (d !== 8'h00) begin errors++; $display("FAIL reset_reg%0d got %h exp 00", a, d); end
    end
    checks++;
    if ({int_req, int_en, int_vec, in_service} !== 21'h0) begin
      errors++; $display("FAIL reset_outs got req=%b en=%h vec=%h ins=%b exp all 0", int_req, int_en, int_vec, in_service);
    end
  endtask

  task automatic test_basic();
    logic [7:0] d;
    do_reset();
    wr(8'hF0, 8'h01); wr(8'hF1, 8'h0F); wr(8'hF3, 8'h80);
    irq[2] = 1; tick();
    rd(8'hF2, d);
    checks++; if (int_req !== 0 || d !== 8'h04) begin errors++; $display("FAIL basic_pend got req=%b pend=%h exp 0/04", int_req, d); end
    tick();
    rd(8'hF2, d);
    checks++;
    if (int_req !== 1 || int_vec !== 8'h88 || in_service !== 4'b0100 || d !== 8'h00) begin
      errors++; $display("FAIL basic_dispatch got req=%b vec=%h ins=%b pend=%h exp 1/88/0100/00", int_req, int_vec, in_service, d);
    end
    tick();
    checks++; if (int_req !== 0) begin errors++; $display("FAIL basic_onecycle got req=%b exp 0", int_req); end
    irq = '0; pulse_ret();
    checks++; if (in_service !== 4'b0000) begin errors++; $display("FAIL basic_ret got ins=%b exp 0000", in_service); end
  endtask

  task automatic test_priority();
    logic [7:0] d;
    do_reset();
    wr(8'hF0, 8'h01); wr(8'hF1, 8'h0F); wr(8'hF3, 8'h80);
    irq = 4'b1010; tick(); tick();
    rd(8'hF2, d);
    checks++;
    if (int_req !== 1 || int_vec !== 8'h84 || in_service !== 4'b0010 || d !== 8'h08) begin
      errors++; $display("FAIL prio_first got req=%b vec=%h ins=%b pend=%h exp 1/84/0010/08", int_req, int_vec, in_service, d);
    end
    tick(); irq = '0; pulse_ret();
    checks++; if (int_req !== 0) begin errors++; $display("FAIL prio_idle got req=%b exp 0", int_req); end
    tick();
    checks++;
    if (int_req !== 1 || int_vec !== 8'h8C || in_service !== 4'b1000) begin
      errors++; $display("FAIL prio_second got req=%b vec=%h ins=%b exp 1/8c/1000", int_req, int_vec, in_service);
    end
    tick(); pulse_ret();
  endtask

  task automatic test_no_nest();
    int seen = 0;
    do_reset();
    wr(8'hF0, 8'h01); wr(8'hF1, 8'h0F); wr(8'hF3, 8'h80);
    irq[1] = 1; tick(); tick(); tick();
    irq[0] = 1;
    for (int i = 0; i < 5; i++) begin tick(); if (int_req) seen++; end
    checks++; if (seen != 0) begin errors++; $display("FAIL nest_blocked got %0d requests exp 0", seen); end
    pulse_ret();
    checks++; if (int_req !== 0) begin errors++; $display("FAIL nest_idle got req=%b exp 0", int_req); end
    tick();
    checks++;
    if (int_req !== 1 || int_vec !== 8'h80 || in_service !== 4'b0001) begin
      errors++; $display("FAIL nest_after_ret got req=%b vec=%h ins=%b exp 1/80/0001", int_req, int_vec, in_service);
    end
    irq = '0; tick(); pulse_ret();
  endtask

  task automatic test_mask();
    logic [7:0] d;
    int seen = 0;
    do_reset();
    wr(8'hF0, 8'h01); wr(8'hF3, 8'h40);
    irq[1] = 1;
    for (int i = 0; i < 3; i++) begin tick(); if (int_req) seen++; end
    rd(8'hF2, d);
    checks++; if (seen != 0 || d !== 8'h02) begin errors++; $display("FAIL mask_hold got reqs=%0d pend=%h exp 0/02", seen, d); end
    wr(8'hF1, 8'h02);
    checks++; if (int_req !== 0) begin errors++; $display("FAIL mask_wr_edge got req=%b exp 0", int_req); end
    tick();
    checks++; if (int_req !== 1 || int_vec !== 8'h44) begin errors++; $display("FAIL mask_release got req=%b vec=%h exp 1/44", int_req, int_vec); end
    tick(); pulse_ret();
    wr(8'hF1, 8'h00); irq = '0; tick(); irq[1] = 1; tick(); tick();
    wr(8'hF2, 8'h02);
    rd(8'hF2, d);
    checks++; if (d !== 8'h00 || int_req !== 0) begin errors++; $display("FAIL mask_wclear got pend=%h req=%b exp 00/0", d, int_req); end
    tick();
    checks++; if (int_req !== 0) begin errors++; $display("FAIL mask_noreq got req=%b exp 0", int_req); end
  endtask

  task automatic test_vbase_en();
    logic [7:0] d;
    logic [7:0] exp_r [5];
    int seen = 0;
    do_reset();
    wr(8'hF0, 8'h01); wr(8'hF1, 8'h0F); wr(8'hF3, 8'hF8);
    irq[3] = 1; tick(); tick();
    checks++; if (int_req !== 1 || int_vec !== 8'h04) begin errors++; $display("FAIL vbase_wrap got req=%b vec=%h exp 1/04", int_req, int_vec); end
    tick(); irq = '0; pulse_ret();
    wr(8'hF0, 8'hA6); wr(8'hF1, 8'hF5); wr(8'hF3, 8'h3C);
    irq[0] = 1;
    for (int i = 0; i < 4; i++) begin tick(); if (int_req) seen++; end
    checks++; if (seen != 0 || int_en !== 8'hA6) begin errors++; $display("FAIL en_off got reqs=%0d en=%h exp 0/a6", seen, int_en); end
    exp_r = '{8'hA6, 8'h05, 8'h01, 8'h3C, 8'h00};
    for (int a = 0; a < 5; a++) begin
      rd(8'hF0 + 8'(a), d);
      checks++; if (d !== exp_r[a]) begin errors++; $display("FAIL readback%0d got %h exp %h", a, d, exp_r[a]); end
    end
  endtask

  task automatic test_async_reset();
    logic [7:0] d;
    do_reset();
    wr(8'hF0, 8'h01); wr(8'hF1, 8'h0F); wr(8'hF3, 8'h20);
    irq[1] = 1; tick(); tick();
    checks++; if (int_req !== 1) begin errors++; $display("FAIL areset_pre got req=%b exp 1", int_req); end
    #2 reset = 1; #1;
    checks++; if (int_req !== 0 || in_service !== 0 || int_vec !== 0) begin
      errors++; $display("FAIL areset_drop got req=%b ins=%b vec=%h exp 0/0/00", int_req, in_service, int_vec);
    end
    irq = '0; #1 reset = 0; tick();
    for (int a = 0; a < 4; a++) begin
      rd(8'hF0 + 8'(a), d);
      checks++; if (d !== 8'h00) begin errors++; $display("FAIL areset_reg%0d got %h exp 00", a, d); end
    end
  endtask

  // Reference model: spec-level register file, pending set and a service phase.
  logic [7:0] m_en, m_vbase, m_vec;
  logic [3:0] m_mask, m_pend, m_irqd, m_ins;
  int         m_phase;  // 0 idle, 1 requesting, 2 servicing

  function automatic logic [7:0] m_read(input logic [7:0] a);
    case (a)
      8'hF0:   return m_en;
      8'hF1:   return {4'h0, m_mask};
      8'hF2:   return {4'h0, m_pend};
      8'hF3:   return m_vbase;
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_clock(input logic [3:0] iv, input logic rv, input logic we,
                             input logic [7:0] a, input logic [7:0] d);
    logic [3:0] clr = '0;
    int w = -1;
    for (int i = 3; i >= 0; i--) if (m_pend[i] && m_mask[i]) w = i;
    if (m_phase == 0 && m_en[0] && w >= 0) begin
      clr = 4'(1 << w); m_vec = m_vbase + 8'(w * 4); m_ins = 4'(1 << w); m_phase = 1;
    end else if (m_phase == 1) m_phase = 2;
    else if (m_phase == 2 && rv) begin m_phase = 0; m_ins = '0; end
    if (we) begin
      if (a == 8'hF0) m_en = d;
      if (a == 8'hF1) m_mask = d[3:0];
      if (a == 8'hF2) clr = clr | d[3:0];
      if (a == 8'hF3) m_vbase = d;
    end
    m_pend = (m_pend & ~clr) | (iv & ~m_irqd);
    m_irqd = iv;
  endtask

  task automatic test_random();
    logic [7:0] addrs [7];
    logic [7:0] er;
    addrs = '{8'hF0, 8'hF1, 8'hF2, 8'hF3, 8'hF4, 8'hEF, 8'h12};
    do_reset();
    m_en = 0; m_vbase = 0; m_vec = 0; m_mask = 0; m_pend = 0; m_irqd = 0; m_ins = 0; m_phase = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 4; b++) if ($urandom_range(7) == 0) irq[b] = ~irq[b];
      ret = ($urandom_range(2) == 0);
      mem_addr = addrs[$urandom_range(6)];
      mem_w_en = ($urandom_range(9) == 0);
      mem_w_data = 8'($urandom);
      if (mem_addr == 8'hF0 && $urandom_range(7) != 0) mem_w_data[0] = 1'b1;
      model_clock(irq, ret, mem_w_en, mem_addr, mem_w_data);
      tick();
      er = m_read(mem_addr);
      checks++;
      if ({int_req, int_en, int_vec, in_service, mem_r_data} !== {(m_phase == 1), m_en, m_vec, m_ins, er}) begin
        errors++;
        $display("FAIL rand_c%0d got req=%b en=%h vec=%h ins=%b rd=%h exp req=%b en=%h vec=%h ins=%b rd=%h",
                 c, int_req, int_en, int_vec, in_service, mem_r_data, (m_phase == 1), m_en, m_vec, m_ins, er);
      end
    end
    mem_w_en = 0; ret = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_priority();
    test_no_nest();
    test_mask();
    test_vbase_en();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
